register_file_mp: RTL
=====================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter N_RD, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, when 1 register 0 reads 0 and ignores writes.
REQ-005 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to matching read ports.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 write  input  1  write request for the current cycle.
REQ-009 wr_addr  input  ADDR_W  target register of write.
REQ-010 wr_data  input  DATA_W  write data.
REQ-011 wr_be  input  DATA_W/8  byte enables; bit i gates wr_data[8i+7:8i].
REQ-012 rd_addr  input  N_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W].
REQ-013 rd_data  output  N_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W].
REQ-014 clr_req  input  1  request sequential clear of all registers.
REQ-015 clr_busy  output  1  high while clear sweep is in progress.
REQ-016 wr_err  output  1  one-cycle pulse: write dropped because sweep was active.

Function
REQ-017 Write: on rising edge with write=1, rst=1, clr_busy=0, bytes with wr_be=1 of reg[wr_addr] SHALL take wr_data; bytes with wr_be=0 unchanged.
REQ-018 ZERO_REG=1: writes to address 0 discarded without error; rd_data for address 0 always 0.
REQ-019 Reads combinational: rd_data port k = reg[rd_addr k] in same cycle, no clock latency.
REQ-020 BYPASS=1: if write accepted this cycle and rd_addr k == wr_addr (non-zero when ZERO_REG=1), port k SHALL show stored value merged with enabled wr_data bytes in the same cycle.
REQ-021 BYPASS=0: written value visible on rd_data the cycle after the write edge.
REQ-022 All N_RD ports may address the same register simultaneously; each returns identical data.
REQ-023 Clear FSM states IDLE, SWEEP; IDLE->SWEEP on edge with clr_req=1; counter loads 0.
REQ-024 SWEEP: each edge zeroes reg[counter] and increments counter; after zeroing DEPTH-1, SWEEP->IDLE; clr_busy high exactly DEPTH cycles.
REQ-025 clr_busy SHALL be asserted combinationally from state==SWEEP.
REQ-026 While clr_busy=1, rd_data SHALL read 0 on all ports regardless of address.
REQ-027 clr_req while SWEEP ignored (no restart, no extension).
REQ-028 write=1 while SWEEP: write dropped, wr_err=1 for the following cycle; no bypass forwarding.
REQ-029 clr_req and write same cycle in IDLE: write performed on that edge, sweep starts same edge, written data is cleared by the sweep.
REQ-030 Counter wraps never: stops at DEPTH-1; no out-of-range access.

Reset
REQ-031 rst=0 at a rising edge SHALL zero all DEPTH registers in parallel, force IDLE, counter 0, wr_err 0.
REQ-032 Reset mid-sweep aborts sweep; clr_busy=0 the cycle after the reset edge.
REQ-033 Reset dominates write and clr_req in the same cycle.

Structure
REQ-034 Package register_file_pkg SHALL hold the FSM state enum (IDLE, SWEEP) and default parameter constants.
REQ-035 Sub-module rf_read_port (address mux, zero-reg and bypass logic) SHALL be instantiated N_RD times via generate.

Verification
REQ-036 Reset, write 555 to r5 and 333 to r3, then rd_addr0=5, rd_addr1=3 -> rd_data0=555, rd_data1=333.
REQ-037 BYPASS=1: write 0xDEADBEEF to r7 with rd_addr0=7 same cycle -> rd_data0=0xDEADBEEF before the edge; BYPASS=0 -> old value until after edge.
REQ-038 r2=0x11223344, write 0xAABBCCDD wr_be=4'b0101 -> r2=0x11BB33DD.
REQ-039 Write 0x1234 to r0 (ZERO_REG=1) -> read r0=0, wr_err=0.
REQ-040 Fill r1..r15, pulse clr_req -> clr_busy high 16 cycles, write during sweep gives wr_err pulse, afterwards all reads 0.
REQ-041 Assert rst=0 on sweep cycle 5 -> next cycle clr_busy=0, all registers 0, IDLE.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and default parameter values for the multi-port register file.
package register_file_pkg;

    // Clear-sweep controller states.
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_t;

    // Default parameter values used by register_file_mp.
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_N_RD     = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

endpackage : register_file_pkg

// File: rtl/register_file_rf_read_port.sv
// One combinational read port: address mux, hard-wired zero register,
// same-cycle write forwarding and read masking while a clear sweep runs.
module rf_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_wr_fwd,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [DATA_W-1:0] i_wr_mask,
    input  logic              i_busy,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] w_stored;

    assign w_stored = i_regs[i_rd_addr];

    // Select stored, forwarded or forced-zero data for this port.
    always_comb begin
        // NOTE: o_rd_data gets a default first so every path assigns it and no latch is inferred.
        o_rd_data = w_stored;
        if (BYPASS != 0 && i_wr_fwd && i_rd_addr == i_wr_addr) begin
            o_rd_data = (w_stored & ~i_wr_mask) | (i_wr_data & i_wr_mask);
        end
        if (ZERO_REG != 0 && i_rd_addr == '0) begin
            o_rd_data = '0;
        end
        if (i_busy) begin
            o_rd_data = '0;
        end
    end

endmodule : rf_read_port

// File: rtl/register_file_mp.sv
// Multi-port register file with byte-enabled writes, optional zero register,
// optional write-to-read forwarding and a sequential clear sweep.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_RD     = DEF_N_RD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     wr_err
);

    localparam int              DEPTH = 2 ** ADDR_W;
    localparam int              NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    // NOTE: the storage is a flop array, not a RAM macro, because a reset must zero every entry at once.
    logic [DATA_W-1:0] r_regs [DEPTH];
    clr_state_t        r_state;
    clr_state_t        w_next_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_wr_err;
    logic              w_busy;
    logic              w_wr_acc;
    logic [DATA_W-1:0] w_wr_mask;

    assign w_busy   = (r_state == SWEEP);
    assign clr_busy = w_busy;
    assign wr_err   = r_wr_err;

    // A write lands only when no sweep runs; zero-register writes vanish silently.
    assign w_wr_acc = write && !w_busy && !(ZERO_REG != 0 && wr_addr == '0);

    // Expand byte enables into a bit mask.
    always_comb begin
        w_wr_mask = '0;
        for (int b = 0; b < NB; b++) begin
            w_wr_mask[8*b +: 8] = {8{wr_be[b]}};
        end
    end

    // Clear-sweep next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (clr_req)       w_next_state = SWEEP;
            SWEEP:   if (r_cnt == LAST) w_next_state = IDLE;
            default:                    w_next_state = IDLE;
        endcase
    end

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    // Sweep counter: loads 0 on entry, saturates at the last address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && w_next_state == SWEEP) begin
            r_cnt <= '0;
        end else if (r_state == SWEEP && r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Flag a write that arrived while the sweep owned the array.
    always_ff @(posedge clk) begin
        if (!rst) r_wr_err <= 1'b0;
        else      r_wr_err <= write && w_busy;
    end

    // Register array: parallel reset, sweep zeroing, byte-masked writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_busy) begin
            r_regs[r_cnt] <= '0;
        end else if (w_wr_acc) begin
            r_regs[wr_addr] <= (r_regs[wr_addr] & ~w_wr_mask) | (wr_data & w_wr_mask);
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .i_regs    (r_regs),
            .i_rd_addr (rd_addr[k*ADDR_W +: ADDR_W]),
            .i_wr_fwd  (w_wr_acc),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_wr_mask (w_wr_mask),
            .i_busy    (w_busy),
            .o_rd_data (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule : register_file_mp
